// File: rtl/gb_read_sequencer_if.sv
// ---------------------------------------------------------------------------
// gb_read_sequencer_if
// Output stream of the global-buffer read sequencer: aligned input/weight
// word pairs handed to the PE array under a valid/ready handshake.
//   m_valid   : beat valid                    (master -> slave)
//   m_in_data : input-bank word of the beat   (master -> slave)
//   m_wt_data : weight-bank word of the beat  (master -> slave)
//   m_last    : final beat of the command     (master -> slave)
//   m_ready   : downstream accept             (slave  -> master)
// ---------------------------------------------------------------------------
interface gb_read_sequencer_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_in_data;
  logic [DATA_WIDTH-1:0] m_wt_data;
  logic                  m_last;

  modport master (output m_valid, m_in_data, m_wt_data, m_last, input m_ready);
  modport slave  (input m_valid, m_in_data, m_wt_data, m_last, output m_ready);
endinterface

// File: rtl/gb_read_sequencer.sv
// ---------------------------------------------------------------------------
// gb_read_sequencer
// Walks the input bank (00) on buffer port A and the weight bank (01) on
// port B in lockstep, absorbs the one-cycle buffer read latency and streams
// aligned word pairs through a 2-entry skid FIFO.
//
// Ports
//   clk, rstn         : clock, asynchronous active-low reset
//   start             : command strobe, honoured only when idle
//   in_base, wt_base  : first word address inside the input / weight bank
//   len               : beats to stream (0 completes without a beat)
//   wt_period         : weight reload period (GB_SEQ_WT_REPEAT_EN only)
//   raddr_a, raddr_b  : buffer read addresses, bank bits fixed to 00 / 01
//   dout_a, dout_b    : buffer read data, one cycle after the address
//   m_if              : output stream (master side)
//   busy              : high whenever the sequencer is not idle
//   done              : one-cycle pulse at command completion
//
// Build option
//   GB_SEQ_WT_REPEAT_EN : adds wt_period; the weight address reloads
//                         wt_base after every wt_period issued beats.
// ---------------------------------------------------------------------------
module gb_read_sequencer #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-3:0]   in_base,
  input  logic [ADDR_WIDTH-3:0]   wt_base,
  input  logic [LEN_WIDTH-1:0]    len,
`ifdef GB_SEQ_WT_REPEAT_EN
  input  logic [LEN_WIDTH-1:0]    wt_period,
`endif
  output logic [ADDR_WIDTH-1:0]   raddr_a,
  output logic [ADDR_WIDTH-1:0]   raddr_b,
  input  logic [DATA_WIDTH-1:0]   dout_a,
  input  logic [DATA_WIDTH-1:0]   dout_b,
  gb_read_sequencer_if.master     m_if,
  output logic                    busy,
  output logic                    done
);

  localparam int WAW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] wt_data;
  } entry_t;

  state_e               state_q, state_d;
  logic [WAW-1:0]       in_addr_q, in_addr_d;
  logic [WAW-1:0]       wt_addr_q, wt_addr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 inflight_q, inflight_last_q;
  entry_t               fifo_q [2];
  entry_t               head;
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           occ_q;
  logic [1:0]           pending;
  logic                 issue, issue_last, push, pop;
`ifdef GB_SEQ_WT_REPEAT_EN
  logic [WAW-1:0]       wt_base_q, wt_base_d;
  logic [LEN_WIDTH-1:0] wt_period_q, wt_period_d;
  logic [LEN_WIDTH-1:0] per_cnt_q, per_cnt_d;
`endif

  // Stream side: the FIFO head is the beat on offer.
  assign head           = fifo_q[rd_ptr_q];
  assign m_if.m_valid   = (occ_q != 2'd0);
  assign m_if.m_in_data = head.in_data;
  assign m_if.m_wt_data = head.wt_data;
  assign m_if.m_last    = m_if.m_valid & head.last;

  assign pop  = m_if.m_valid & m_if.m_ready;
  assign push = inflight_q;  // read issued last cycle returns now

  // A read may only be issued if its data is guaranteed a FIFO slot when it
  // returns next cycle; a pop in this cycle frees one slot in time.
  assign pending    = occ_q + {1'b0, inflight_q};
  assign issue      = (state_q == S_RUN) &&
                      ((pending < 2'd2) || ((pending == 2'd2) && pop));
  assign cnt_inc    = cnt_q + LEN_WIDTH'(1);
  assign issue_last = (cnt_inc == len_q);

  assign raddr_a = {2'b00, in_addr_q};
  assign raddr_b = {2'b01, wt_addr_q};
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

  // NOTE: every variable written here gets its default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_addr_d = in_addr_q;
    wt_addr_d = wt_addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
`ifdef GB_SEQ_WT_REPEAT_EN
    wt_base_d   = wt_base_q;
    wt_period_d = wt_period_q;
    per_cnt_d   = per_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          in_addr_d = in_base;
          wt_addr_d = wt_base;
          len_d     = len;
          cnt_d     = '0;
`ifdef GB_SEQ_WT_REPEAT_EN
          wt_base_d   = wt_base;
          wt_period_d = wt_period;
          per_cnt_d   = '0;
`endif
          // An empty command still spends one cycle in DRAIN, which puts
          // done in the second cycle after the strobe.
          state_d = (len == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          cnt_d     = cnt_inc;
          in_addr_d = in_addr_q + WAW'(1);
`ifdef GB_SEQ_WT_REPEAT_EN
          if ((wt_period_q != '0) && (per_cnt_q == wt_period_q - LEN_WIDTH'(1))) begin
            wt_addr_d = wt_base_q;
            per_cnt_d = '0;
          end else begin
            wt_addr_d = wt_addr_q + WAW'(1);
            per_cnt_d = per_cnt_q + LEN_WIDTH'(1);
          end
`else
          wt_addr_d = wt_addr_q + WAW'(1);
`endif
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the last beat is being accepted so done follows
        // that acceptance by exactly one cycle.
        if (!inflight_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      in_addr_q       <= '0;
      wt_addr_q       <= '0;
      len_q           <= '0;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
`ifdef GB_SEQ_WT_REPEAT_EN
      wt_base_q       <= '0;
      wt_period_q     <= '0;
      per_cnt_q       <= '0;
`endif
    end else begin
      state_q         <= state_d;
      in_addr_q       <= in_addr_d;
      wt_addr_q       <= wt_addr_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
`ifdef GB_SEQ_WT_REPEAT_EN
      wt_base_q       <= wt_base_d;
      wt_period_q     <= wt_period_d;
      per_cnt_q       <= per_cnt_d;
`endif
    end
  end

  // NOTE: the two FIFO entries are reset on purpose: the head drives the
  // stream data outputs directly, and those must read zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{last: inflight_last_q, in_data: dout_a, wt_data: dout_b};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_gb_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gb_read_sequencer
// Directed bench for gb_read_sequencer. The buffer model returns the read
// address as data, so every beat's expected words follow from the command.
// Cycle 0 is the cycle in which start is held high; cycle k is sampled in
// the middle of the k-th following clock period.
// ---------------------------------------------------------------------------
module tb_gb_read_sequencer;
  localparam int AW = 17;
  localparam int DW = 128;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [14:0]   in_base = '0;
  logic [14:0]   wt_base = '0;
  logic [LW-1:0] len = '0;
`ifdef GB_SEQ_WT_REPEAT_EN
  logic [LW-1:0] wt_period = '0;
`endif
  logic [AW-1:0] raddr_a, raddr_b;
  logic [DW-1:0] dout_a, dout_b;
  logic          busy, done;

  int total = 0;
  int bad   = 0;

  gb_read_sequencer_if #(.DATA_WIDTH(DW)) m_if ();

  gb_read_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .in_base (in_base),
    .wt_base (wt_base),
    .len     (len),
`ifdef GB_SEQ_WT_REPEAT_EN
    .wt_period (wt_period),
`endif
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .dout_a  (dout_a),
    .dout_b  (dout_b),
    .m_if    (m_if.master),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Global buffer model: one-cycle read latency, data equals address.
  always @(posedge clk) begin
    dout_a <= DW'(raddr_a);
    dout_b <= DW'(raddr_b);
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle capture of the last command, indexed by cycle number.
  logic [AW-1:0] cap_ra [0:127];
  logic [AW-1:0] cap_rb [0:127];
  logic          cap_v [0:127];
  logic          cap_last [0:127];
  logic          cap_done [0:127];
  logic          cap_busy [0:127];
  int            done_cyc;
  int            beats;

  // Runs one command. bp selects the 1,0,0,1 m_ready pattern; mid_cyc pulses
  // a conflicting start in that cycle; rst_cyc asserts reset in that cycle.
  // Every accepted beat is scored against the expected address sequence.
  task automatic run_cmd(input logic [14:0] ib, input logic [14:0] wb, input logic [LW-1:0] ln,
                         input logic [LW-1:0] per, input bit bp, input int mid_cyc, input int rst_cyc);
    logic [DW-1:0] prev_in, prev_wt;
    logic [14:0]   issued, woff;
    bit            prev_stall, finished;
    beats = 0; done_cyc = -1; prev_stall = 0; finished = 0;
    prev_in = '0; prev_wt = '0;
    for (int i = 0; i < 128; i++) begin
      cap_ra[i] = '0; cap_rb[i] = '0; cap_v[i] = 0;
      cap_last[i] = 0; cap_done[i] = 0; cap_busy[i] = 0;
    end
    @(negedge clk);
    start = 1'b1; in_base = ib; wt_base = wb; len = ln; m_if.m_ready = 1'b1;
`ifdef GB_SEQ_WT_REPEAT_EN
    wt_period = per;
`endif
    for (int cyc = 1; cyc < 128 && !finished; cyc++) begin
      @(negedge clk);
      start = (cyc == mid_cyc);
      if (cyc == mid_cyc) begin
        in_base = 15'h0300; wt_base = 15'h0400; len = 9;
      end
      m_if.m_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (cyc == rst_cyc) begin
        rstn = 1'b0;
        #1;
        check("rst_raddr_a", DW'(raddr_a), DW'(17'h00000));
        check("rst_raddr_b", DW'(raddr_b), DW'(17'h08000));
        check("rst_busy",    DW'(busy), 0);
        check("rst_done",    DW'(done), 0);
        check("rst_valid",   DW'(m_if.m_valid), 0);
        check("rst_last",    DW'(m_if.m_last), 0);
        check("rst_in_data", m_if.m_in_data, '0);
        check("rst_wt_data", m_if.m_wt_data, '0);
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      #1;
      cap_ra[cyc] = raddr_a; cap_rb[cyc] = raddr_b; cap_v[cyc] = m_if.m_valid;
      cap_last[cyc] = m_if.m_last; cap_done[cyc] = done; cap_busy[cyc] = busy;
      // Reads issued before this edge minus beats accepted = occupancy + inflight.
      issued = raddr_a[14:0] - ib;
      check("outstanding_le2", DW'((issued - 15'(beats)) <= 15'd2), 1);
      if (prev_stall) begin
        check("stall_valid", DW'(m_if.m_valid), 1);
        check("stall_in",    m_if.m_in_data, prev_in);
        check("stall_wt",    m_if.m_wt_data, prev_wt);
      end
      if (m_if.m_valid && m_if.m_ready) begin
        woff = (per == '0) ? 15'(beats) : 15'(beats % int'(per));
        check("beat_in",   m_if.m_in_data, DW'({2'b00, 15'(ib + 15'(beats))}));
        check("beat_wt",   m_if.m_wt_data, DW'({2'b01, 15'(wb + woff)}));
        check("beat_last", DW'(m_if.m_last), DW'(beats == int'(ln) - 1));
        beats++;
      end
      prev_stall = m_if.m_valid && !m_if.m_ready;
      prev_in    = m_if.m_in_data;
      prev_wt    = m_if.m_wt_data;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) finished = 1;
    end
    check("cmd_completed", DW'(finished), 1);
    check("beat_count",    DW'(beats), DW'(ln));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] wrap_exp [4];
    logic [AW-1:0] rep_exp [7];
    wrap_exp = '{17'h07FFE, 17'h07FFF, 17'h00000, 17'h00001};
    rep_exp  = '{17'h08100, 17'h08101, 17'h08102, 17'h08100, 17'h08101, 17'h08102, 17'h08100};

    // Reset state.
    m_if.m_ready = 1'b1;
    #12;
    check("init_raddr_a", DW'(raddr_a), DW'(17'h00000));
    check("init_raddr_b", DW'(raddr_b), DW'(17'h08000));
    check("init_busy",    DW'(busy), 0);
    check("init_valid",   DW'(m_if.m_valid), 0);
    check("init_in_data", m_if.m_in_data, '0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic stream.
    run_cmd(15'h0010, 15'h0020, 4, 0, 0, -1, -1);
    for (int k = 1; k <= 4; k++) begin
      check("t1_raddr_a", DW'(cap_ra[k]), DW'(17'h00010 + 17'(k - 1)));
      check("t1_raddr_b", DW'(cap_rb[k]), DW'(17'h08020 + 17'(k - 1)));
    end
    for (int k = 1; k <= 8; k++) begin
      check("t1_valid", DW'(cap_v[k]),    DW'(k >= 3 && k <= 6));
      check("t1_last",  DW'(cap_last[k]), DW'(k == 6));
      check("t1_done",  DW'(cap_done[k]), DW'(k == 7));
      check("t1_busy",  DW'(cap_busy[k]), DW'(k <= 7));
    end

    // Backpressure.
    run_cmd(15'h0100, 15'h0200, 8, 0, 1, -1, -1);

    // Address wrap inside the input bank.
    run_cmd(15'h7FFE, 15'h0000, 4, 0, 0, -1, -1);
    for (int k = 1; k <= 4; k++)
      check("wrap_raddr_a", DW'(cap_ra[k]), DW'(wrap_exp[k-1]));

    // Empty command.
    run_cmd(15'h0055, 15'h0066, 0, 0, 0, -1, -1);
    for (int k = 1; k <= 3; k++) begin
      check("len0_busy",  DW'(cap_busy[k]), DW'(k <= 2));
      check("len0_done",  DW'(cap_done[k]), DW'(k == 2));
      check("len0_valid", DW'(cap_v[k]), 0);
    end

    // Start pulsed while running is ignored.
    run_cmd(15'h0040, 15'h0050, 4, 0, 0, 2, -1);
    for (int k = 1; k <= 4; k++)
      check("busy_start_raddr_a", DW'(cap_ra[k]), DW'(17'h00040 + 17'(k - 1)));
    check("busy_start_done_cyc", DW'(done_cyc), 7);

    // Reset mid-command, then a fresh command from a new base.
    run_cmd(15'h0500, 15'h0600, 16, 0, 0, -1, 5);
    run_cmd(15'h00A0, 15'h00B0, 2, 0, 0, -1, -1);
    check("post_rst_raddr_a", DW'(cap_ra[1]), DW'(17'h000A0));
    check("post_rst_raddr_b", DW'(cap_rb[1]), DW'(17'h080B0));

`ifdef GB_SEQ_WT_REPEAT_EN
    // Weight reuse.
    run_cmd(15'h0000, 15'h0100, 7, 3, 0, -1, -1);
    for (int k = 1; k <= 7; k++)
      check("repeat_raddr_b", DW'(cap_rb[k]), DW'(rep_exp[k-1]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
